cursor_controller: RTL and testbench

//   Parametrised cursor engine for the VGA paint path. Debounces five push-buttons and

---
 rtl/cursor_pkg.sv | 50 +++++
 rtl/button_debouncer.sv | 44 ++++
 rtl/cursor_controller.sv | 144 ++++++++++++++
 tb/tb_cursor_controller.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/cursor_pkg.sv
// Shared types, screen defaults and the per-axis position arithmetic for the cursor engine.
package cursor_pkg;

  localparam int SCREEN_MAX_X = 639;
  localparam int SCREEN_MAX_Y = 479;

  localparam int BTN_RIGHT  = 0;
  localparam int BTN_LEFT   = 1;
  localparam int BTN_UP     = 2;
  localparam int BTN_DOWN   = 3;
  localparam int BTN_CENTER = 4;
  localparam int NUM_BTN    = 5;

  typedef enum logic [1:0] {IDLE, SLOW, FAST} hold_state_t;
  typedef enum logic [1:0] {DIR_NONE, DIR_POS, DIR_NEG} dir_t;

  // Opposing buttons cancel, so holding both reads as no motion on that axis.
  function automatic dir_t axis_dir(input logic pos, input logic neg);
    dir_t d;
    case ({pos, neg})
      2'b10:   d = DIR_POS;
      2'b01:   d = DIR_NEG;
      default: d = DIR_NONE;
    endcase
    return d;
  endfunction

  // Arithmetic is done 32 bits wide so p+s can never overflow before the edge test.
  function automatic logic [31:0] axis_next(input logic [31:0] p,
                                            input logic [31:0] s,
                                            input logic [31:0] max_p,
                                            input dir_t        dir,
                                            input logic        wrap);
    logic [31:0] r;
    r = p;
    case (dir)
      DIR_POS: begin
        if (p + s > max_p) r = wrap ? (p + s - (max_p + 32'd1)) : max_p;
        else               r = p + s;
      end
      DIR_NEG: begin
        if (p < s) r = wrap ? (p + (max_p + 32'd1) - s) : 32'd0;
        else       r = p - s;
      end
      default: r = p;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchroniser followed by a stable-sample counter; the clean level follows the
// synchronised input once it has differed for DEB_CYCLES consecutive cycles.
module button_debouncer
  import cursor_pkg::*;
#(
  parameter int DEB_CYCLES = 500_000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic clean
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          clean_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      clean_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking so sync2_q takes the previous sync1_q and the chain stays two flops deep.
      sync1_q <= raw;
      sync2_q <= sync1_q;
      if (sync2_q == clean_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        clean_q <= sync2_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign clean = clean_q;

endmodule

// File: rtl/cursor_controller.sv
// Cursor engine: debounced buttons drive a tick-paced cursor with hold-to-accelerate,
// clamp/wrap edges, and a paint level plus start pulse from the centre button.
module cursor_controller
  import cursor_pkg::*;
#(
  parameter int MAX_X       = SCREEN_MAX_X,
  parameter int MAX_Y       = SCREEN_MAX_Y,
  parameter int TICK_DIV    = 1_000_000,
  parameter int DEB_CYCLES  = 500_000,
  parameter int ACCEL_TICKS = 16,
  parameter int STEP_FAST   = 4,
  localparam int WX = $clog2(MAX_X + 1),
  localparam int WY = $clog2(MAX_Y + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          btn_right,
  input  logic          btn_left,
  input  logic          btn_up,
  input  logic          btn_down,
  input  logic          btn_center,
  input  logic          wrap_en,
  output logic [WX-1:0] cursor_x,
  output logic [WY-1:0] cursor_y,
  output logic          paint,
  output logic          paint_start,
  output logic          fast
);

  localparam int TCW = $clog2(TICK_DIV);
  localparam int HCW = $clog2(ACCEL_TICKS + 1);
  localparam logic [TCW-1:0] TICK_LAST  = TCW'(TICK_DIV - 1);
  localparam logic [HCW-1:0] ACCEL_LAST = HCW'(ACCEL_TICKS);

  logic [NUM_BTN-1:0] btn_raw, btn_clean;

  assign btn_raw[BTN_RIGHT]  = btn_right;
  assign btn_raw[BTN_LEFT]   = btn_left;
  assign btn_raw[BTN_UP]     = btn_up;
  assign btn_raw[BTN_DOWN]   = btn_down;
  assign btn_raw[BTN_CENTER] = btn_center;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_deb
    button_debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk   (clk),
      .reset (reset),
      .raw   (btn_raw[i]),
      .clean (btn_clean[i])
    );
  end

  logic [TCW-1:0] tick_cnt_q;
  logic           tick;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   tick_cnt_q <= '0;
    else if (tick_cnt_q == TICK_LAST) tick_cnt_q <= '0;
    else                         tick_cnt_q <= tick_cnt_q + 1'b1;
  end

  assign tick = (tick_cnt_q == TICK_LAST);

  dir_t dx, dy;
  logic any_dir;

  assign dx      = axis_dir(btn_clean[BTN_RIGHT], btn_clean[BTN_LEFT]);
  assign dy      = axis_dir(btn_clean[BTN_DOWN],  btn_clean[BTN_UP]);
  assign any_dir = (dx != DIR_NONE) || (dy != DIR_NONE);

  hold_state_t    state_q;
  logic [HCW-1:0] hold_cnt_q, hold_cnt_d;
  logic           fast_q;
  logic [WX-1:0]  x_q, x_d;
  logic [WY-1:0]  y_q, y_d;
  logic [31:0]    step, x_next, y_next;

  always_comb begin
    // NOTE: every output of this block gets a value up front so no path leaves one unassigned (no latch).
    step       = (state_q == FAST) ? 32'(STEP_FAST) : 32'd1;
    x_next     = axis_next(32'(x_q), step, 32'(MAX_X), dx, wrap_en);
    y_next     = axis_next(32'(y_q), step, 32'(MAX_Y), dy, wrap_en);
    x_d        = WX'(x_next);
    y_d        = WY'(y_next);
    hold_cnt_d = hold_cnt_q + 1'b1;
  end

  // Releasing every direction drops to IDLE on any cycle; movement only happens on tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      hold_cnt_q <= '0;
      fast_q     <= 1'b0;
      x_q        <= WX'(MAX_X / 2);
      y_q        <= WY'(MAX_Y / 2);
    end else if (!any_dir) begin
      state_q    <= IDLE;
      hold_cnt_q <= '0;
      fast_q     <= 1'b0;
    end else if (tick) begin
      x_q <= x_d;
      y_q <= y_d;
      case (state_q)
        IDLE: begin
          hold_cnt_q <= HCW'(1);
          if (ACCEL_TICKS == 1) begin
            state_q <= FAST;
            fast_q  <= 1'b1;
          end else begin
            state_q <= SLOW;
          end
        end
        SLOW: begin
          hold_cnt_q <= hold_cnt_d;
          if (hold_cnt_d == ACCEL_LAST) begin
            state_q <= FAST;
            fast_q  <= 1'b1;
          end
        end
        FAST: begin
          fast_q <= 1'b1;
        end
        default: begin
          state_q    <= IDLE;
          hold_cnt_q <= '0;
          fast_q     <= 1'b0;
        end
      endcase
    end
  end

  logic paint_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) paint_q <= 1'b0;
    else       paint_q <= btn_clean[BTN_CENTER];
  end

  assign cursor_x    = x_q;
  assign cursor_y    = y_q;
  assign fast        = fast_q;
  assign paint       = paint_q;
  assign paint_start = btn_clean[BTN_CENTER] & ~paint_q;

endmodule

// File: tb/tb_cursor_controller.sv
// Directed bench for cursor_controller with small timing parameters and a position model.
module tb_cursor_controller;

  localparam int MAX_X     = 639;
  localparam int MAX_Y     = 479;
  localparam int TICK_DIV  = 4;
  localparam int DEB       = 3;
  localparam int ACCEL     = 3;
  localparam int STEP_FAST = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_right, btn_left, btn_up, btn_down, btn_center;
  logic       wrap_en;
  logic [9:0] cursor_x;
  logic [8:0] cursor_y;
  logic       paint, paint_start, fast;

  int errors = 0;
  int checks = 0;
  int mx, my, hold_k;

  always #5 clk = ~clk;

  cursor_controller #(
    .MAX_X(MAX_X), .MAX_Y(MAX_Y), .TICK_DIV(TICK_DIV),
    .DEB_CYCLES(DEB), .ACCEL_TICKS(ACCEL), .STEP_FAST(STEP_FAST)
  ) dut (
    .clk(clk), .reset(reset),
    .btn_right(btn_right), .btn_left(btn_left), .btn_up(btn_up),
    .btn_down(btn_down), .btn_center(btn_center), .wrap_en(wrap_en),
    .cursor_x(cursor_x), .cursor_y(cursor_y),
    .paint(paint), .paint_start(paint_start), .fast(fast)
  );

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  function automatic int next_pos(input int p, input int s, input int mp, input int sgn, input bit wrap);
    if (sgn > 0) return (p + s > mp) ? (wrap ? p + s - (mp + 1) : mp) : p + s;
    if (sgn < 0) return (p < s) ? (wrap ? p + mp + 1 - s : 0) : p - s;
    return p;
  endfunction

  // Expect the next tick's move on one axis (0 = x, 1 = y); returns on the negedge after it.
  task automatic step_expect(input int axis, input int sgn, input string tag);
    int s, cur, exp_p;
    bit moved;
    hold_k++;
    s     = (hold_k > ACCEL) ? STEP_FAST : 1;
    cur   = (axis == 0) ? mx : my;
    exp_p = next_pos(cur, s, (axis == 0) ? MAX_X : MAX_Y, sgn, wrap_en);
    if (exp_p == cur) begin
      repeat (TICK_DIV) @(negedge clk);
    end else begin
      moved = 1'b0;
      for (int i = 0; i < 40 && !moved; i++) begin
        @(negedge clk);
        moved = (axis == 0) ? (cursor_x != 10'(cur)) : (cursor_y != 9'(cur));
      end
      check({tag, "_moved"}, 32'(moved), 32'd1);
    end
    check(tag, (axis == 0) ? 32'(cursor_x) : 32'(cursor_y), 32'(exp_p));
    check({tag, "_other"}, (axis == 0) ? 32'(cursor_y) : 32'(cursor_x), (axis == 0) ? 32'(my) : 32'(mx));
    check({tag, "_fast"}, 32'(fast), 32'(hold_k >= ACCEL));
    if (axis == 0) mx = exp_p;
    else           my = exp_p;
  endtask

  // Releasing right after a move still allows exactly one more tick before the debounced release.
  task automatic release_all(input int axis, input int sgn, input string tag);
    btn_right = 1'b0; btn_left = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    step_expect(axis, sgn, {tag, "_last"});
    repeat (TICK_DIV) @(negedge clk);
    check({tag, "_fast_off"}, 32'(fast), 32'd0);
    hold_k = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, required finish");
    $fatal(1);
  end

  initial begin
    int pulses;
    reset = 1'b1; wrap_en = 1'b0;
    btn_right = 1'b0; btn_left = 1'b0; btn_up = 1'b0; btn_down = 1'b0; btn_center = 1'b0;
    mx = 319; my = 239; hold_k = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_x", 32'(cursor_x), 32'd319);
    check("rst_y", 32'(cursor_y), 32'd239);
    check("rst_paint", 32'(paint), 32'd0);
    check("rst_pstart", 32'(paint_start), 32'd0);
    check("rst_fast", 32'(fast), 32'd0);

    // Right hold: 320,321,322 (FAST) then 326,330; reset mid-motion.
    btn_right = 1'b1;
    for (int i = 0; i < 5; i++) step_expect(0, 1, "accel_right");
    reset = 1'b1;
    #1;
    check("midrst_x", 32'(cursor_x), 32'd319);
    check("midrst_y", 32'(cursor_y), 32'd239);
    check("midrst_fast", 32'(fast), 32'd0);
    check("midrst_paint", 32'(paint), 32'd0);
    btn_right = 1'b0;
    mx = 319; my = 239; hold_k = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Single-cycle glitches on up never pass the debouncer.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk) btn_up = 1'b1;
      @(negedge clk) btn_up = 1'b0;
      repeat (2) @(negedge clk);
    end
    repeat (12) @(negedge clk);
    check("glitch_y", 32'(cursor_y), 32'd239);
    check("glitch_x", 32'(cursor_x), 32'd319);
    check("glitch_fast", 32'(fast), 32'd0);

    // Left+right cancel; down moves y: 240,241,242, release extra 246.
    btn_left = 1'b1; btn_right = 1'b1; btn_down = 1'b1;
    for (int i = 0; i < 3; i++) step_expect(1, 1, "lr_down");
    release_all(1, 1, "lr_down_rel");

    // Clamp right: 320..638 then 639, 639; then wrap to 3, release extra 7.
    btn_right = 1'b1;
    for (int i = 0; i < 84; i++) step_expect(0, 1, "clamp_right");
    check("clamp_x_edge", 32'(cursor_x), 32'd639);
    wrap_en = 1'b1;
    step_expect(0, 1, "wrap_right");
    release_all(0, 1, "wrap_right_rel");

    // Re-press left from IDLE with wrap: 6,5,4,0,636, release extra 632.
    btn_left = 1'b1;
    for (int i = 0; i < 5; i++) step_expect(0, -1, "wrap_left");
    release_all(0, -1, "wrap_left_rel");

    // Up with wrap from y=246: ... 3 -> 479 in FAST, release extra 475.
    btn_up = 1'b1;
    for (int i = 0; i < 64; i++) step_expect(1, -1, "wrap_up");
    release_all(1, -1, "wrap_up_rel");

    // Clamp down: 476,477,478, 479, release tick stays at 479.
    wrap_en = 1'b0;
    btn_down = 1'b1;
    for (int i = 0; i < 4; i++) step_expect(1, 1, "clamp_down");
    release_all(1, 1, "clamp_down_rel");

    // Centre press: one paint_start pulse then paint level; release gives no pulse.
    pulses = 0;
    @(negedge clk) btn_center = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      pulses += int'(paint_start);
    end
    check("paint_start_pulses", 32'(pulses), 32'd1);
    check("paint_on", 32'(paint), 32'd1);
    check("paint_x_still", 32'(cursor_x), 32'(mx));
    check("paint_y_still", 32'(cursor_y), 32'(my));
    pulses = 0;
    btn_center = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      pulses += int'(paint_start);
    end
    check("release_pulses", 32'(pulses), 32'd0);
    check("paint_off", 32'(paint), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
